// File: rtl/csi_tx_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : csi_tx_packetizer
// Purpose  : CSI-2 protocol-layer packetizer. Turns a camera pixel stream into
//            FS / [LS] / long packet / [LE] / FE byte stream with SOP/EOP
//            delimiters and a valid/ready output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module csi_tx_packetizer #(
  parameter int         PIX_W    = 14,
  parameter int         CNT_W    = 16,
  parameter logic [5:0] DT_RAW8  = 6'h2A,
  parameter logic [5:0] DT_RAW10 = 6'h2B,
  parameter logic [5:0] DT_RAW12 = 6'h2C,
  parameter logic [5:0] DT_RAW14 = 6'h2D,
  parameter logic [5:0] DT_FS    = 6'h00,
  parameter logic [5:0] DT_FE    = 6'h01,
  parameter logic [5:0] DT_LS    = 6'h02,
  parameter logic [5:0] DT_LE    = 6'h03
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       cfg_mode,
  input  logic [1:0]       cfg_vc,
  input  logic [CNT_W-1:0] cfg_line_pixels,
  input  logic [CNT_W-1:0] cfg_lines,
  input  logic             cfg_ls_le_en,
  input  logic             frame_req,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic [7:0]       byte_data,
  output logic             byte_sop,
  output logic             byte_eop,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             err_sync,
  output logic             err_cfg
);

  localparam logic [3:0] S_IDLE  = 4'd0, S_FS = 4'd1, S_LS = 4'd2, S_LH = 4'd3,
                         S_PCOL  = 4'd4, S_PEMIT = 4'd5, S_LF = 4'd6, S_LE = 4'd7,
                         S_FE    = 4'd8, S_DONE = 4'd9;
  localparam logic [1:0] C_RAW8 = 2'd0, C_RAW10 = 2'd1, C_RAW12 = 2'd2;

  logic [3:0]       r_state, w_state_nxt;
  logic [1:0]       r_mode, r_vc;
  logic [CNT_W-1:0] r_line_pixels, r_lines, r_line, r_px_cnt, r_frame_cnt;
  logic             r_ls_le, r_first_grp;
  logic [15:0]      r_wc;
  logic [2:0]       r_idx;
  logic [1:0]       r_gi;
  logic [PIX_W-1:0] r_pix [4];
  logic [7:0]       r_csum;
  logic             r_byte_valid, r_byte_sop, r_byte_eop, r_err_sync, r_err_cfg;
  logic [7:0]       r_byte_data;

  logic             w_cfg_ok, w_load, w_emit_state, w_emit, w_step, w_pix_acc;
  logic             w_last_line, w_line_done, w_sop, w_eop;
  logic [CNT_W-1:0] w_wc_calc;
  logic [2:0]       w_last_idx, w_grp_bytes_last;
  logic [1:0]       w_grp_last;
  logic [5:0]       w_dt, w_dt_long;
  logic [15:0]      w_field;
  logic [7:0]       w_hdr0, w_pay, w_byte;

  assign w_cfg_ok     = (cfg_line_pixels != '0) && (cfg_line_pixels[1:0] == 2'b00) && (cfg_lines != '0);
  // Output register may take a new byte when empty or being drained this cycle.
  assign w_load       = !r_byte_valid || byte_ready;
  assign w_emit_state = (r_state == S_FS) || (r_state == S_LS) || (r_state == S_LH) ||
                        (r_state == S_PEMIT) || (r_state == S_LF) || (r_state == S_LE) ||
                        (r_state == S_FE);
  assign w_emit       = w_emit_state && w_load;
  assign w_step       = w_emit && (r_idx == w_last_idx);
  assign w_pix_acc    = (r_state == S_PCOL) && pix_valid;
  assign w_last_line  = (r_line == r_lines);
  assign w_line_done  = (r_px_cnt == r_line_pixels);
  assign w_hdr0       = {r_vc, w_dt};

  // Word count from line pixels with shifts/adds only (line pixels is a multiple of 4).
  always_comb begin
    case (cfg_mode)
      C_RAW8:  w_wc_calc = cfg_line_pixels;
      C_RAW10: w_wc_calc = cfg_line_pixels + (cfg_line_pixels >> 2);
      C_RAW12: w_wc_calc = cfg_line_pixels + (cfg_line_pixels >> 1);
      default: w_wc_calc = cfg_line_pixels + (cfg_line_pixels >> 1) + (cfg_line_pixels >> 2);
    endcase
  end

  // Per-mode group geometry and long-packet data type.
  always_comb begin
    case (r_mode)
      C_RAW8:  begin w_grp_last = 2'd0; w_grp_bytes_last = 3'd0; w_dt_long = DT_RAW8;  end
      C_RAW10: begin w_grp_last = 2'd3; w_grp_bytes_last = 3'd4; w_dt_long = DT_RAW10; end
      C_RAW12: begin w_grp_last = 2'd1; w_grp_bytes_last = 3'd2; w_dt_long = DT_RAW12; end
      default: begin w_grp_last = 2'd3; w_grp_bytes_last = 3'd6; w_dt_long = DT_RAW14; end
    endcase
  end

  // Header data type and 16-bit field for the packet currently being emitted.
  always_comb begin
    w_dt    = DT_FS;
    w_field = 16'(r_frame_cnt);
    case (r_state)
      S_FE:    w_dt = DT_FE;
      S_LS:    begin w_dt = DT_LS; w_field = 16'(r_line); end
      S_LE:    begin w_dt = DT_LE; w_field = 16'(r_line); end
      S_LH:    begin w_dt = w_dt_long; w_field = r_wc; end
      default: ;
    endcase
  end

  // Payload byte r_idx of the collected pixel group: MSB bytes first, then packed LSBs.
  always_comb begin
    case (r_mode)
      C_RAW8:  w_pay = r_pix[0][7:0];
      C_RAW10: w_pay = (r_idx == 3'd4) ? {r_pix[3][1:0], r_pix[2][1:0], r_pix[1][1:0], r_pix[0][1:0]}
                                       : r_pix[r_idx[1:0]][9:2];
      C_RAW12: begin
        case (r_idx)
          3'd0:    w_pay = r_pix[0][11:4];
          3'd1:    w_pay = r_pix[1][11:4];
          default: w_pay = {r_pix[1][3:0], r_pix[0][3:0]};
        endcase
      end
      default: begin
        case (r_idx)
          3'd4:    w_pay = {r_pix[1][1:0], r_pix[0][5:0]};
          3'd5:    w_pay = {r_pix[2][3:0], r_pix[1][5:2]};
          3'd6:    w_pay = {r_pix[3][5:0], r_pix[2][5:4]};
          default: w_pay = r_pix[r_idx[1:0]][13:6];
        endcase
      end
    endcase
  end

  // Next byte and its delimiters; payload+footer form one delimited unit per line.
  always_comb begin
    w_byte     = 8'h00;
    w_sop      = 1'b0;
    w_eop      = 1'b0;
    w_last_idx = 3'd3;
    case (r_state)
      S_PEMIT: begin
        w_byte     = w_pay;
        w_sop      = r_first_grp && (r_idx == 3'd0);
        w_last_idx = w_grp_bytes_last;
      end
      S_LF: begin
        w_byte     = r_csum;
        w_eop      = (r_idx == 3'd1);
        w_last_idx = 3'd1;
      end
      default: begin
        case (r_idx[1:0])
          2'd0:    w_byte = w_hdr0;
          2'd1:    w_byte = w_field[7:0];
          2'd2:    w_byte = w_field[15:8];
          default: w_byte = w_hdr0 ^ w_field[7:0] ^ w_field[15:8];
        endcase
        w_sop = (r_idx == 3'd0);
        w_eop = (r_idx == 3'd3);
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic; emitting states advance after their last byte is loaded.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (frame_req && w_cfg_ok) w_state_nxt = S_FS;
      S_FS:    if (w_step) w_state_nxt = r_ls_le ? S_LS : S_LH;
      S_LS:    if (w_step) w_state_nxt = S_LH;
      S_LH:    if (w_step) w_state_nxt = S_PCOL;
      S_PCOL:  if (w_pix_acc && (r_gi == w_grp_last)) w_state_nxt = S_PEMIT;
      S_PEMIT: if (w_step) w_state_nxt = w_line_done ? S_LF : S_PCOL;
      S_LF:    if (w_step) w_state_nxt = r_ls_le ? S_LE : (w_last_line ? S_FE : S_LH);
      S_LE:    if (w_step) w_state_nxt = w_last_line ? S_FE : S_LS;
      S_FE:    if (w_step) w_state_nxt = S_DONE;
      S_DONE:  if (r_byte_valid && byte_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy      = (r_state != S_IDLE);
    pix_ready = (r_state == S_PCOL);
  end

  // Config latch, byte index, pixel group capture, checksum, line and frame counters, errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode        <= '0;
      r_vc          <= '0;
      r_line_pixels <= '0;
      r_lines       <= '0;
      r_ls_le       <= 1'b0;
      r_wc          <= '0;
      r_line        <= '0;
      r_px_cnt      <= '0;
      r_frame_cnt   <= CNT_W'(1);
      r_idx         <= '0;
      r_gi          <= '0;
      r_csum        <= '0;
      r_first_grp   <= 1'b0;
      r_err_sync    <= 1'b0;
      r_err_cfg     <= 1'b0;
      for (int i = 0; i < 4; i++) r_pix[i] <= '0;
    end else begin
      if ((r_state == S_IDLE) && frame_req && w_cfg_ok) begin
        r_mode        <= cfg_mode;
        r_vc          <= cfg_vc;
        r_line_pixels <= cfg_line_pixels;
        r_lines       <= cfg_lines;
        r_ls_le       <= cfg_ls_le_en;
        r_wc          <= 16'(w_wc_calc);
        r_line        <= CNT_W'(1);
      end
      if (w_step)      r_idx <= '0;
      else if (w_emit) r_idx <= r_idx + 3'd1;
      if (r_state == S_LH) begin
        r_px_cnt    <= '0;
        r_gi        <= '0;
        r_csum      <= '0;
        r_first_grp <= 1'b1;
      end
      if (w_pix_acc) begin
        r_pix[r_gi] <= pix_data;
        r_gi        <= (r_gi == w_grp_last) ? 2'd0 : r_gi + 2'd1;
        r_px_cnt    <= r_px_cnt + CNT_W'(1);
      end
      if (w_emit && (r_state == S_PEMIT)) begin
        r_csum      <= r_csum ^ w_pay;
        r_first_grp <= 1'b0;
      end
      if (w_step && !w_last_line && (((r_state == S_LF) && !r_ls_le) || (r_state == S_LE)))
        r_line <= r_line + CNT_W'(1);
      // Frame number skips 0 on wrap.
      if ((r_state == S_DONE) && r_byte_valid && byte_ready)
        r_frame_cnt <= (r_frame_cnt == '1) ? CNT_W'(1) : r_frame_cnt + CNT_W'(1);
      if (frame_req && (r_state != S_IDLE))         r_err_sync <= 1'b1;
      if (frame_req && (r_state == S_IDLE) && !w_cfg_ok) r_err_cfg <= 1'b1;
    end
  end

  // Output byte register: loads only when empty or draining, so data holds under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_valid <= 1'b0;
      r_byte_data  <= '0;
      r_byte_sop   <= 1'b0;
      r_byte_eop   <= 1'b0;
    end else if (w_emit) begin
      r_byte_valid <= 1'b1;
      r_byte_data  <= w_byte;
      r_byte_sop   <= w_sop;
      r_byte_eop   <= w_eop;
    end else if (byte_ready) begin
      r_byte_valid <= 1'b0;
    end
  end

  assign byte_valid = r_byte_valid;
  assign byte_data  = r_byte_data;
  assign byte_sop   = r_byte_sop;
  assign byte_eop   = r_byte_eop;
  assign frame_cnt  = r_frame_cnt;
  assign err_sync   = r_err_sync;
  assign err_cfg    = r_err_cfg;

endmodule
`default_nettype wire

// File: tb/tb_csi_tx_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_csi_tx_packetizer
// Purpose  : Self-checking bench for csi_tx_packetizer: random frames compared
//            against a byte-stream reference model, plus directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csi_tx_packetizer;
  localparam int PIX_W = 14;
  localparam int CNT_W = 16;
  localparam int LIMIT = 3000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       cfg_mode = '0, cfg_vc = '0;
  logic [CNT_W-1:0] cfg_line_pixels = '0, cfg_lines = '0;
  logic             cfg_ls_le_en = 1'b0, frame_req = 1'b0;
  logic             pix_valid, pix_ready, byte_valid, byte_ready, byte_sop, byte_eop;
  logic [PIX_W-1:0] pix_data;
  logic [7:0]       byte_data;
  logic             busy, err_sync, err_cfg;
  logic [CNT_W-1:0] frame_cnt;

  csi_tx_packetizer #(.PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_vc(cfg_vc),
    .cfg_line_pixels(cfg_line_pixels), .cfg_lines(cfg_lines), .cfg_ls_le_en(cfg_ls_le_en),
    .frame_req(frame_req), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .byte_sop(byte_sop), .byte_eop(byte_eop), .busy(busy), .frame_cnt(frame_cnt),
    .err_sync(err_sync), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int ready_pct = 100;
  int valid_pct = 100;
  int exp_fcnt = 1;
  logic [13:0] q_pix[$];
  logic [13:0] q_drv[$];
  logic [9:0]  q_got[$];
  logic [9:0]  q_exp[$];

  task automatic chk_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pixel source: presents queued pixels with random gaps.
  initial begin
    pix_valid = 1'b0;
    pix_data  = '0;
    forever begin
      @(negedge clk);
      if (q_drv.size() > 0 && $urandom_range(99) < valid_pct) begin
        pix_valid = 1'b1;
        pix_data  = q_drv[0];
      end else begin
        pix_valid = 1'b0;
      end
      if (pix_valid && pix_ready) void'(q_drv.pop_front());
    end
  end

  // Byte sink: random ready, records transfers, checks stability while stalled.
  initial begin
    logic       stall;
    logic [9:0] held;
    stall = 1'b0;
    held  = '0;
    byte_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (stall && rst_n)
        chk_value("hold_stable", {byte_valid, byte_sop, byte_eop, byte_data}, {1'b1, held});
      byte_ready = ($urandom_range(99) < ready_pct);
      if (byte_valid && byte_ready) q_got.push_back({byte_sop, byte_eop, byte_data});
      stall = byte_valid && !byte_ready;
      held  = {byte_sop, byte_eop, byte_data};
    end
  end

  task automatic push_short(input int dt, input int vc, input int field);
    logic [7:0] b0, b1, b2;
    b0 = 8'((vc << 6) | dt);
    b1 = 8'(field);
    b2 = 8'(field >> 8);
    q_exp.push_back({2'b10, b0});
    q_exp.push_back({2'b00, b1});
    q_exp.push_back({2'b00, b2});
    q_exp.push_back({2'b01, b0 ^ b1 ^ b2});
  endtask

  // Reference: pixel width W = 8+2*mode; each pixel's top 8 bits, then the low
  // (W-8) bits of the group concatenated little-endian and split into bytes.
  task automatic model_frame(input int mode, input int vc, input int lp, input int lines,
                             input int lsle, input int fcnt);
    int w, l, g, wc, pi, p;
    longint word;
    logic [7:0] cs;
    logic [7:0] pay[$];
    w = 8 + 2 * mode;
    l = w - 8;
    g = (mode == 0) ? 1 : (mode == 2) ? 2 : 4;
    wc = lp * w / 8;
    pi = 0;
    push_short(0, vc, fcnt);
    for (int ln = 1; ln <= lines; ln++) begin
      cs = 8'h00;
      pay.delete();
      if (lsle != 0) push_short(2, vc, ln);
      push_short(8'h2A + mode, vc, wc);
      for (int gs = 0; gs < lp; gs += g) begin
        word = 0;
        for (int k = 0; k < g; k++) begin
          p = int'(q_pix[pi + k]);
          pay.push_back(8'(p >> l));
          word = word | (longint'(p & ((1 << l) - 1)) << (k * l));
        end
        for (int b = 0; b < g * l / 8; b++) pay.push_back(8'(word >> (8 * b)));
        pi += g;
      end
      foreach (pay[i]) begin
        cs = cs ^ pay[i];
        q_exp.push_back({(i == 0), 1'b0, pay[i]});
      end
      q_exp.push_back({2'b00, cs});
      q_exp.push_back({2'b01, cs});
      if (lsle != 0) push_short(3, vc, ln);
    end
    push_short(1, vc, fcnt);
  endtask

  // Runs one frame and compares the captured byte stream to the model.
  task automatic run_frame(input int mode, input int vc, input int lp, input int lines,
                           input int lsle, input bit own_pix, input int sync_at, input string tag);
    int cyc;
    int n;
    if (!own_pix) begin
      q_pix.delete();
      repeat (lp * lines) q_pix.push_back(14'($urandom));
    end
    q_exp.delete();
    q_got.delete();
    model_frame(mode, vc, lp, lines, lsle, exp_fcnt);
    q_drv = q_pix;
    @(negedge clk);
    cfg_mode = 2'(mode); cfg_vc = 2'(vc); cfg_line_pixels = CNT_W'(lp);
    cfg_lines = CNT_W'(lines); cfg_ls_le_en = (lsle != 0);
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    chk_value({tag, "_busy_rise"}, busy, 1);
    cyc = 0;
    while (busy && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      frame_req = (sync_at != 0) && (cyc == sync_at);
    end
    frame_req = 1'b0;
    chk_value({tag, "_done"}, busy, 0);
    chk_value({tag, "_len"}, q_got.size(), q_exp.size());
    n = (q_got.size() < q_exp.size()) ? q_got.size() : q_exp.size();
    for (int i = 0; i < n; i++) chk_value($sformatf("%s_b%0d", tag, i), q_got[i], q_exp[i]);
    exp_fcnt = (exp_fcnt == 65535) ? 1 : exp_fcnt + 1;
    chk_value({tag, "_fcnt"}, frame_cnt, exp_fcnt);
  endtask

  task automatic chk_byte(input string tag, input int idx, input logic [7:0] exp);
    logic [9:0] v;
    v = (idx < q_got.size()) ? q_got[idx] : 10'h3FF;
    chk_value($sformatf("%s_%0d", tag, idx), v[7:0], exp);
  endtask

  initial begin
    logic [7:0] lit14 [21];
    int sop_at[4];
    int eop_at[4];
    int cyc;
    lit14 = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h2D, 8'h07, 8'h00, 8'h2A,
              8'hFF, 8'h00, 8'h00, 8'h00, 8'h3F, 8'h00, 8'h00, 8'hC0, 8'hC0,
              8'h01, 8'h01, 8'h00, 8'h00};
    sop_at = '{0, 4, 8, 17};
    eop_at = '{3, 7, 16, 20};

    repeat (3) @(negedge clk);
    chk_value("rst_byte_valid", byte_valid, 0);
    chk_value("rst_busy", busy, 0);
    chk_value("rst_frame_cnt", frame_cnt, 1);
    chk_value("rst_errs", {err_sync, err_cfg, pix_ready}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed RAW14 vector with literal expected bytes.
    q_pix = '{14'h3FFF, 14'h0, 14'h0, 14'h0};
    run_frame(3, 0, 4, 1, 0, 1'b1, 0, "raw14");
    for (int i = 0; i < 21; i++) chk_byte("raw14_lit", i, lit14[i]);
    for (int i = 0; i < 4; i++) begin
      if (sop_at[i] < q_got.size()) chk_value($sformatf("raw14_sop%0d", i), q_got[sop_at[i]][9], 1);
      if (eop_at[i] < q_got.size()) chk_value($sformatf("raw14_eop%0d", i), q_got[eop_at[i]][8], 1);
    end

    // Directed RAW10, vc=1.
    q_pix = '{14'h3FF, 14'h1, 14'h2, 14'h3};
    run_frame(1, 1, 4, 1, 0, 1'b1, 0, "raw10");
    chk_byte("raw10_lh", 4, 8'h6B); chk_byte("raw10_lh", 5, 8'h05);
    chk_byte("raw10_lh", 7, 8'h6E); chk_byte("raw10_pay", 8, 8'hFF);
    chk_byte("raw10_pay", 12, 8'hE7); chk_byte("raw10_cs", 13, 8'h18);
    chk_byte("raw10_cs", 14, 8'h18);

    // RAW12, two lines, LS/LE enabled.
    run_frame(2, 0, 4, 2, 1, 1'b0, 0, "raw12");
    chk_byte("raw12_ls1", 5, 8'h01); chk_byte("raw12_lh", 8, 8'h2C);
    chk_byte("raw12_lh", 9, 8'h06); chk_byte("raw12_lh", 11, 8'h2A);
    chk_byte("raw12_ls2", 25, 8'h02); chk_byte("raw12_le2", 40, 8'h03);
    chk_byte("raw12_fe", 44, 8'h01);
    chk_value("no_err_yet", {err_sync, err_cfg}, 0);

    // Randomized frames, half under 50% backpressure and sparse pixels.
    for (int f = 0; f < 8; f++) begin
      ready_pct = (f % 2 == 0) ? 50 : 100;
      valid_pct = (f % 2 == 0) ? 60 : 100;
      run_frame($urandom_range(3), $urandom_range(3), 4 * $urandom_range(1, 5),
                $urandom_range(1, 3), $urandom_range(1), 1'b0, 0, $sformatf("rnd%0d", f));
    end
    ready_pct = 100;
    valid_pct = 100;

    // Frame request mid-frame: flagged, frame unchanged.
    run_frame(0, 2, 8, 2, 1, 1'b0, 15, "sync");
    chk_value("err_sync_set", err_sync, 1);
    chk_value("err_cfg_clear", err_cfg, 0);

    // Invalid configurations: no frame starts.
    q_got.delete();
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      cfg_line_pixels = (t == 0) ? CNT_W'(6) : CNT_W'(8);
      cfg_lines = (t == 0) ? CNT_W'(1) : CNT_W'(0);
      frame_req = 1'b1;
      @(negedge clk);
      frame_req = 1'b0;
      chk_value($sformatf("badcfg%0d_busy", t), busy, 0);
      repeat (8) @(negedge clk);
      chk_value($sformatf("badcfg%0d_err", t), err_cfg, 1);
      chk_value($sformatf("badcfg%0d_nobytes", t), q_got.size(), 0);
    end

    // Frame counter wrap from 0xFFFF back to 1.
    @(negedge clk);
    force dut.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_cnt;
    @(negedge clk);
    exp_fcnt = 65535;
    chk_value("wrap_preload", frame_cnt, 16'hFFFF);
    run_frame(0, 0, 4, 1, 0, 1'b0, 0, "wrapA");
    chk_byte("wrapA_fs", 1, 8'hFF); chk_byte("wrapA_fs", 2, 8'hFF);
    run_frame(0, 0, 4, 1, 0, 1'b0, 0, "wrapB");
    chk_byte("wrapB_fs", 1, 8'h01); chk_byte("wrapB_fs", 2, 8'h00);

    // Reset asserted mid-payload.
    q_pix.delete();
    repeat (16) q_pix.push_back(14'($urandom));
    q_drv = q_pix;
    q_got.delete();
    @(negedge clk);
    cfg_mode = 2'd0; cfg_line_pixels = CNT_W'(16); cfg_lines = CNT_W'(1); cfg_ls_le_en = 1'b0;
    frame_req = 1'b1;
    @(negedge clk);
    frame_req = 1'b0;
    cyc = 0;
    while (q_got.size() < 11 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    chk_value("midrst_reached", q_got.size() >= 11, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_value("midrst_valid", byte_valid, 0);
    chk_value("midrst_fcnt", frame_cnt, 1);
    chk_value("midrst_busy", busy, 0);
    q_drv.delete();
    q_got.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk_value("midrst_quiet", q_got.size(), 0);
    exp_fcnt = 1;
    run_frame(2, 3, 8, 1, 1, 1'b0, 0, "postrst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
